// File: rtl/add_lanes_pkg.sv
// Shared types and sizing helpers for the streaming lane adder task.
package add_lanes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    EOT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Sizing for the default 32-bit, 2-lane build; instances derive theirs from sum_w().
  localparam int SUM_W = 32 + $clog2(2);
  localparam logic [31:0] MAX_VAL = {32{1'b1}};

  // Adding num_in values of width bits needs $clog2(num_in) carry bits.
  function automatic int sum_w(input int width, input int num_in);
    return width + $clog2(num_in);
  endfunction

endpackage

// File: rtl/add_lanes_tree.sv
// Combinational N-input unsigned adder; optionally clamps to all ones on overflow.
module add_lanes_tree
  import add_lanes_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 2,
  parameter int SATURATE = 0
) (
  input  logic [NUM_IN-1:0][WIDTH-1:0] lanes,
  output logic [WIDTH-1:0]             sum
);

  localparam int LSUM_W = sum_w(WIDTH, NUM_IN);
  localparam logic [WIDTH-1:0] LMAX_VAL = {WIDTH{1'b1}};

  logic [LSUM_W-1:0] acc;
  logic              ovf;

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_IN; i++) acc = acc + LSUM_W'(lanes[i]);
  end

  assign ovf = |acc[LSUM_W-1:WIDTH];
  assign sum = ((SATURATE != 0) && ovf) ? LMAX_VAL : acc[WIDTH-1:0];

endmodule

// File: rtl/add_lanes_task.sv
// ap_ctrl_hs leaf task: sums NUM_IN eot-tagged streams element-wise into one stream
// and closes it with an eot token.
module add_lanes_task
  import add_lanes_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 2,
  parameter int CNT_W     = 64,
  parameter int SATURATE  = 0,
  parameter int DRAIN_EOT = 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [CNT_W-1:0]        n,
  input  logic [NUM_IN*WIDTH-1:0] in_s_dout,
  input  logic [NUM_IN-1:0]       in_s_dout_eot,
  input  logic [NUM_IN-1:0]       in_s_empty_n,
  output logic [NUM_IN-1:0]       in_s_read,
  output logic [WIDTH-1:0]        c_din,
  output logic                    c_din_eot,
  input  logic                    c_full_n,
  output logic                    c_write
);

  localparam state_t TAIL = (DRAIN_EOT != 0) ? DRAIN : EOT;

  state_t            state;
  logic [CNT_W-1:0]  n_r, cnt;
  logic [NUM_IN-1:0] lane_done, lane_done_nxt;
  logic              out_valid, tok;
  logic [WIDTH-1:0]  sum;
  logic              room, push, fire;

  add_lanes_tree #(
    .WIDTH   (WIDTH),
    .NUM_IN  (NUM_IN),
    .SATURATE(SATURATE)
  ) u_tree (
    .lanes(in_s_dout),
    .sum  (sum)
  );

  assign room = !out_valid || c_full_n;
  assign push = out_valid && c_full_n;
  assign fire = (state == RUN) && (&in_s_empty_n) && room;

  // Draining lanes pop independently until each has seen its own eot.
  always_comb begin
    in_s_read = '0;
    if (fire) in_s_read = '1;
    else if (state == DRAIN) in_s_read = ~lane_done & in_s_empty_n;
  end

  assign lane_done_nxt = lane_done | (in_s_read & in_s_dout_eot);

  assign c_write  = out_valid;
  assign ap_idle  = (state == IDLE);
  assign ap_done  = (state == DONE);
  assign ap_ready = (state == DONE);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      tok       <= 1'b0;
      cnt       <= '0;
      n_r       <= '0;
      lane_done <= '0;
      c_din     <= '0;
      c_din_eot <= 1'b0;
    end else begin
      if (push) out_valid <= 1'b0;
      case (state)
        IDLE: if (ap_start) begin
          n_r       <= n;
          cnt       <= '0;
          lane_done <= '0;
          tok       <= 1'b0;
          state     <= (n == '0) ? TAIL : RUN;
        end
        RUN: if (fire) begin
          if (|in_s_dout_eot) begin
            // Early abort: heads are popped but no sum is produced.
            lane_done <= in_s_dout_eot;
            state     <= TAIL;
          end else begin
            out_valid <= 1'b1;
            c_din     <= sum;
            c_din_eot <= 1'b0;
            if (cnt == n_r - CNT_W'(1)) state <= TAIL;
            else cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          lane_done <= lane_done_nxt;
          if (&lane_done_nxt) state <= EOT;
        end
        EOT: begin
          if (!tok) begin
            if (room) begin
              out_valid <= 1'b1;
              c_din     <= '0;
              c_din_eot <= 1'b1;
              tok       <= 1'b1;
            end
          end else if (push) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_lanes_task.sv
// Directed bench: 32-bit 2-lane task driven from per-lane queues, plus 8-bit 3-lane
// saturating / wrapping instances checked against a vector table.
module tb_add_lanes_task;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 32-bit, 2-lane, wrapping instance
  logic        start0;
  logic [63:0] n0;
  logic [63:0] dout0;
  logic [1:0]  eot0, empn0, rd0;
  logic [31:0] cdin0;
  logic        ceot0, cfull0, cwr0, done0, idle0, ready0;

  add_lanes_task #(.WIDTH(32), .NUM_IN(2), .CNT_W(64), .SATURATE(0), .DRAIN_EOT(1)) dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start0), .ap_done(done0), .ap_idle(idle0),
    .ap_ready(ready0), .n(n0), .in_s_dout(dout0), .in_s_dout_eot(eot0), .in_s_empty_n(empn0),
    .in_s_read(rd0), .c_din(cdin0), .c_din_eot(ceot0), .c_full_n(cfull0), .c_write(cwr0)
  );

  // 8-bit, 3-lane instances, saturating (1) and wrapping (2), sharing inputs
  logic        start8;
  logic [7:0]  n8;
  logic [23:0] d8;
  logic [2:0]  eot8, empn8, rd1, rd2;
  logic        cfull8;
  logic [7:0]  cdin1, cdin2;
  logic        ceot1, ceot2, cwr1, cwr2, done1, done2, idle1, idle2, ready1, ready2;

  add_lanes_task #(.WIDTH(8), .NUM_IN(3), .CNT_W(8), .SATURATE(1), .DRAIN_EOT(1)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start8), .ap_done(done1), .ap_idle(idle1),
    .ap_ready(ready1), .n(n8), .in_s_dout(d8), .in_s_dout_eot(eot8), .in_s_empty_n(empn8),
    .in_s_read(rd1), .c_din(cdin1), .c_din_eot(ceot1), .c_full_n(cfull8), .c_write(cwr1)
  );

  add_lanes_task #(.WIDTH(8), .NUM_IN(3), .CNT_W(8), .SATURATE(0), .DRAIN_EOT(1)) dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start8), .ap_done(done2), .ap_idle(idle2),
    .ap_ready(ready2), .n(n8), .in_s_dout(d8), .in_s_dout_eot(eot8), .in_s_empty_n(empn8),
    .in_s_read(rd2), .c_din(cdin2), .c_din_eot(ceot2), .c_full_n(cfull8), .c_write(cwr2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // stream model state for dut0
  logic [32:0] q0[$], q1[$], outq[$], exp_q[$];
  bit          bp_en = 1'b0;
  logic [3:0]  bp_pat = 4'b1001;   // c_full_n sequence 1,0,0,1
  int          bp_idx = 0;
  bit          hold_pend = 1'b0;
  logic [32:0] held;
  int          cyc = 0, pops0 = 0, done_cyc = -1, push_cyc = -100;
  logic [63:0] n_cur;
  bit          got8;

  task automatic drive();
    if (q0.size() > 0) begin
      empn0[0] = 1'b1; eot0[0] = q0[0][32]; dout0[31:0] = q0[0][31:0];
    end else begin
      empn0[0] = 1'b0; eot0[0] = 1'b0; dout0[31:0] = '0;
    end
    if (q1.size() > 0) begin
      empn0[1] = 1'b1; eot0[1] = q1[0][32]; dout0[63:32] = q1[0][31:0];
    end else begin
      empn0[1] = 1'b0; eot0[1] = 1'b0; dout0[63:32] = '0;
    end
    cfull0 = bp_en ? bp_pat[bp_idx % 4] : 1'b1;
  endtask

  // Sample at negedge, account for the handshakes of the coming edge, re-drive after it.
  task automatic tick();
    @(negedge clk);
    chk("read_while_empty", 64'(rd0 & ~empn0), 64'd0);
    if (hold_pend) begin
      chk("bp_hold_write", 64'(cwr0), 64'd1);
      chk("bp_hold_data", 64'({ceot0, cdin0}), 64'(held));
    end
    if (bp_en && (64'(pops0) < n_cur) && cwr0 && !cfull0) chk("bp_no_pop", 64'(rd0), 64'd0);
    hold_pend = cwr0 && !cfull0;
    held = {ceot0, cdin0};
    if (cwr0 && cfull0) begin
      outq.push_back({ceot0, cdin0});
      if (ceot0) push_cyc = cyc;
    end
    if (done0) begin
      done_cyc = cyc;
      chk("ready_with_done", 64'(ready0), 64'd1);
    end
    if (rd0[0] && q0.size() > 0) begin
      if (!q0[0][32]) pops0++;
      void'(q0.pop_front());
    end
    if (rd0[1] && q1.size() > 0) void'(q1.pop_front());
    cyc++;
    @(posedge clk);
    #1;
    bp_idx++;
    drive();
  endtask

  task automatic run0(input string nm, input logic [63:0] nv, input int limit);
    outq.delete();
    pops0 = 0; n_cur = nv; done_cyc = -1; push_cyc = -100;
    drive();
    n0 = nv; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < limit && done_cyc < 0; i++) tick();
    chk({nm, "_done_reached"}, 64'(done_cyc >= 0), 64'd1);
    chk({nm, "_done_after_eot_push"}, 64'(done_cyc), 64'(push_cyc + 1));
    chk({nm, "_out_count"}, 64'(outq.size()), 64'(exp_q.size()));
    for (int i = 0; i < outq.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_out%0d", nm, i), 64'(outq[i]), 64'(exp_q[i]));
    chk({nm, "_inputs_consumed"}, 64'(q0.size() + q1.size()), 64'd0);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, 64'({done0, idle0}), 64'b01);
  endtask

  function automatic logic [32:0] d(input logic [31:0] v);
    return {1'b0, v};
  endfunction

  localparam logic [32:0] EOTK = {1'b1, 32'd0};

  typedef struct {
    logic [7:0] a, b, c;
    logic [7:0] sat, wrap;
  } vec_t;
  vec_t vt[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'd200, 8'd100, 8'd1,   8'd255, 8'd45};
    vt[1] = '{8'd1,   8'd2,   8'd3,   8'd6,   8'd6};
    vt[2] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd255};
    vt[3] = '{8'd85,  8'd85,  8'd85,  8'd255, 8'd255};
    vt[4] = '{8'd86,  8'd85,  8'd85,  8'd255, 8'd0};
    vt[5] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd253};
    vt[6] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0};

    rst_n = 1'b0; start0 = 1'b0; n0 = '0;
    start8 = 1'b0; n8 = '0; d8 = '0; eot8 = '0; empn8 = '0; cfull8 = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dut0", 64'({idle0, done0, ready0, cwr0, rd0}), 64'b100000);
    chk("rst_dut1", 64'({idle1, done1, ready1, cwr1, rd1}), 64'b1000000);

    // 1: basic n=4
    q0 = '{d(1), d(2), d(3), d(4), EOTK};
    q1 = '{d(10), d(20), d(30), d(40), EOTK};
    exp_q = '{d(11), d(22), d(33), d(44), EOTK};
    run0("basic", 64'd4, 50);

    // 2: n=0, only eot tokens on the inputs
    q0 = '{EOTK}; q1 = '{EOTK};
    exp_q = '{EOTK};
    run0("n_zero", 64'd0, 30);

    // 4: backpressure with a 32-bit wrap in the first element
    bp_en = 1'b1; bp_idx = 0;
    q0 = '{d(5), d(6), d(7), d(8), d(9), d(10), EOTK};
    q1 = '{d(32'hFFFF_FFFF), d(1), d(2), d(3), d(4), d(5), EOTK};
    exp_q = '{d(4), d(7), d(9), d(11), d(13), d(15), EOTK};
    run0("backpressure", 64'd6, 100);
    bp_en = 1'b0; hold_pend = 1'b0;

    // 5: early abort, lane0 ends after 2 elements, lane1 after 4
    q0 = '{d(1), d(2), EOTK};
    q1 = '{d(100), d(200), d(300), d(400), EOTK};
    exp_q = '{d(101), d(202), EOTK};
    run0("abort", 64'd5, 50);

    // 6: reset mid-RUN, then a fresh task
    q0 = '{d(1), d(2), d(3), d(4), EOTK};
    q1 = '{d(10), d(20), d(30), d(40), EOTK};
    drive();
    n0 = 64'd4; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    drive();
    @(negedge clk);
    chk("midrst_state", 64'({idle0, done0, cwr0, rd0}), 64'b10000);
    q0 = '{d(1), d(2), d(3), d(4), EOTK};
    q1 = '{d(10), d(20), d(30), d(40), EOTK};
    exp_q = '{d(11), d(22), d(33), d(44), EOTK};
    run0("after_rst", 64'd4, 50);

    // 3: saturating vs wrapping 8-bit, 3 lanes, n=1 per vector
    for (int k = 0; k < 7; k++) begin
      d8 = {vt[k].c, vt[k].b, vt[k].a}; eot8 = '0; empn8 = '1; n8 = 8'd1; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      got8 = 1'b0;
      for (int w = 0; w < 20 && !got8; w++) begin
        @(negedge clk);
        if (cwr1) got8 = 1'b1;
      end
      chk($sformatf("vec%0d_write", k), 64'({got8, cwr2, ceot1}), 64'b110);
      chk($sformatf("vec%0d_sat", k), 64'(cdin1), 64'(vt[k].sat));
      chk($sformatf("vec%0d_wrap", k), 64'(cdin2), 64'(vt[k].wrap));
      @(posedge clk);
      #1 eot8 = '1; d8 = '0;
      got8 = 1'b0;
      for (int w = 0; w < 20 && !got8; w++) begin
        @(negedge clk);
        if (done1 && done2) got8 = 1'b1;
      end
      chk($sformatf("vec%0d_done", k), 64'(got8), 64'd1);
      @(posedge clk);
      #1 empn8 = '0; eot8 = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
